ir_a2d_seq: RTL and testbench

Parametrised IR line-sensor scan sequencer for the motion-control path, generalising the fixed three-pair IR/A2D scan to NUM_PAIRS sensor pairs.
- For each pair: enable the pair's IR emitter, wait a settle time, convert the left then the right channel through the shared A2D handshake (strt_cnv/chnnl/cnv_cmplt/A2D_res), and accumulate a binary-weighted left-minus-right difference.
- At the end of a scan: publish a saturated signed error, with a valid pulse, to the PI controller.

---
 rtl/ir_seq_pkg.sv | 38 +++
 rtl/ir_a2d_seq_accum.sv | 44 ++++
 rtl/ir_a2d_seq.sv | 202 ++++++++++++++++++++
 tb/tb_ir_a2d_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_seq_pkg.sv
// Shared types and helpers for the IR line-sensor scan sequencer:
// FSM state encoding, channel mapping, accumulator sizing and saturation.
package ir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CNV_L,
    WAIT_L,
    CNV_R,
    WAIT_R,
    DONE
  } state_t;

  function automatic int acc_width(input int res_w, input int num_pairs, input int wgt_shift);
    return res_w + (num_pairs - 1) * wgt_shift + 2;
  endfunction

  function automatic int unsigned left_ch(input int unsigned k);
    return 2 * k;
  endfunction

  function automatic int unsigned right_ch(input int unsigned k);
    return 2 * k + 1;
  endfunction

  // Clamp a wide signed value into the range of an err_w-bit signed number.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int err_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (err_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (err_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ir_a2d_seq_accum.sv
// Weighted left-minus-right accumulator for one scan; exposes the running
// value saturated to the published error width.
module ir_err_accum
  import ir_seq_pkg::*;
#(
  parameter int RES_W     = 12,
  parameter int NUM_PAIRS = 3,
  parameter int WGT_SHIFT = 3,
  parameter int ERR_W     = 16,
  parameter int KW        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic                    sub_en,
  input  logic [KW-1:0]           k,
  input  logic [RES_W-1:0]        res,
  output logic signed [ERR_W-1:0] err_sat
);

  localparam int ACC_W = acc_width(RES_W, NUM_PAIRS, WGT_SHIFT);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;

  // Width leaves two spare bits, so the sum of all pairs can never wrap.
  assign term = ACC_W'(res) << (32'(k) * WGT_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + term;
    end else if (sub_en) begin
      acc <= acc - term;
    end
  end

  assign err_sat = ERR_W'(sat_to(64'(acc), ERR_W));

endmodule

// File: rtl/ir_a2d_seq.sv
// IR line-sensor scan sequencer: NUM_PAIRS emitter/A2D pairs -> weighted error.
// Optional A2D watchdog enabled by defining IR_SEQ_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | emitters off, waiting for go
//   SETTLE | emitter k on, counting down the settle time
//   CNV_L  | start pulse for left channel of pair k
//   WAIT_L | waiting for left result
//   CNV_R  | start pulse for right channel of pair k
//   WAIT_R | waiting for right result
//   DONE   | publish saturated error, restart or go idle
module ir_a2d_seq
  import ir_seq_pkg::*;
#(
  parameter int NUM_PAIRS   = 3,
  parameter int RES_W       = 12,
  parameter int CH_W        = 3,
  parameter int SETTLE_CYC  = 4096,
  parameter int WGT_SHIFT   = 3,
  parameter int ERR_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic                    strt_cnv,
  output logic [CH_W-1:0]         chnnl,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        A2D_res,
  output logic [NUM_PAIRS-1:0]    ir_en,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_vld,
  output logic                    busy,
  output logic                    a2d_err
);

  localparam int KW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_t                  state;
  logic [KW-1:0]           k;
  logic [SW-1:0]           settle_cnt;
  logic signed [ERR_W-1:0] err_sat;
  logic                    acc_clr;
  logic                    acc_add;
  logic                    acc_sub;

  assign acc_clr = (state == IDLE) || (state == DONE);
  assign acc_add = (state == WAIT_L) && cnv_cmplt;
  assign acc_sub = (state == WAIT_R) && cnv_cmplt;

  ir_err_accum #(
    .RES_W    (RES_W),
    .NUM_PAIRS(NUM_PAIRS),
    .WGT_SHIFT(WGT_SHIFT),
    .ERR_W    (ERR_W),
    .KW       (KW)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .add_en (acc_add),
    .sub_en (acc_sub),
    .k      (k),
    .res    (A2D_res),
    .err_sat(err_sat)
  );

`ifdef IR_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_expired;

  // Loaded during the start pulse so the first WAIT cycle sees TIMEOUT_CYC-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == CNV_L || state == CNV_R) begin
      wd_cnt <= WW'(TIMEOUT_CYC - 1);
    end else if ((state == WAIT_L || state == WAIT_R) && wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign wd_expired = (wd_cnt == '0);
`else
  // Without the watchdog the flag is constant low.
  assign a2d_err = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      settle_cnt <= '0;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      ir_en      <= '0;
      err        <= '0;
      err_vld    <= 1'b0;
      busy       <= 1'b0;
`ifdef IR_SEQ_TIMEOUT_EN
      a2d_err    <= 1'b0;
`endif
    end else begin
      strt_cnv <= 1'b0;
      err_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state      <= SETTLE;
            k          <= '0;
            ir_en      <= NUM_PAIRS'(1);
            settle_cnt <= SW'(SETTLE_CYC - 1);
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (!go) begin
            state <= IDLE;
            ir_en <= '0;
            busy  <= 1'b0;
          end else if (settle_cnt == '0) begin
            state    <= CNV_L;
            strt_cnv <= 1'b1;
            chnnl    <= CH_W'(left_ch(32'(k)));
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CNV_L: state <= WAIT_L;
        WAIT_L: begin
          if (cnv_cmplt) begin
            if (!go) begin
              state <= IDLE;
              ir_en <= '0;
              busy  <= 1'b0;
            end else begin
              state    <= CNV_R;
              strt_cnv <= 1'b1;
              chnnl    <= CH_W'(right_ch(32'(k)));
            end
          end
`ifdef IR_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state   <= IDLE;
            ir_en   <= '0;
            busy    <= 1'b0;
            a2d_err <= 1'b1;
          end
`endif
        end
        CNV_R: state <= WAIT_R;
        WAIT_R: begin
          if (cnv_cmplt) begin
            if (!go) begin
              state <= IDLE;
              ir_en <= '0;
              busy  <= 1'b0;
            end else if (k == KW'(NUM_PAIRS - 1)) begin
              state <= DONE;
              ir_en <= '0;
            end else begin
              state      <= SETTLE;
              k          <= k + 1'b1;
              ir_en      <= ir_en << 1;
              settle_cnt <= SW'(SETTLE_CYC - 1);
            end
          end
`ifdef IR_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state   <= IDLE;
            ir_en   <= '0;
            busy    <= 1'b0;
            a2d_err <= 1'b1;
          end
`endif
        end
        DONE: begin
          err     <= err_sat;
          err_vld <= 1'b1;
          if (go) begin
            state      <= SETTLE;
            k          <= '0;
            ir_en      <= NUM_PAIRS'(1);
            settle_cnt <= SW'(SETTLE_CYC - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ir_en <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_a2d_seq.sv
// Self-checking bench for ir_a2d_seq: one default instance (full settle time)
// and one ERR_W=12 / short-settle instance for vectors, random scans and go-drop.
module tb_ir_a2d_seq;

  typedef struct packed {
    logic [11:0] l0, r0, l1, r1, l2, r2;
  } scan_t;

  typedef struct packed {
    scan_t              s;
    logic signed [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               go_a, cmplt_a, strt_a, vld_a, busy_a, a2e_a;
  logic [11:0]        res_a;
  logic [2:0]         ch_a, ir_a;
  logic signed [15:0] err_a;

  logic               go_b, cmplt_b, strt_b, vld_b, busy_b, a2e_b;
  logic [11:0]        res_b;
  logic [2:0]         ch_b, ir_b;
  logic signed [11:0] err_b;

  ir_a2d_seq dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .strt_cnv(strt_a), .chnnl(ch_a),
    .cnv_cmplt(cmplt_a), .A2D_res(res_a), .ir_en(ir_a), .err(err_a),
    .err_vld(vld_a), .busy(busy_a), .a2d_err(a2e_a)
  );

  ir_a2d_seq #(.ERR_W(12), .SETTLE_CYC(8), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .strt_cnv(strt_b), .chnnl(ch_b),
    .cnv_cmplt(cmplt_b), .A2D_res(res_b), .ir_en(ir_b), .err(err_b),
    .err_vld(vld_b), .busy(busy_b), .a2d_err(a2e_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: sum over pairs of (L-R)*2^(3k), clamped to errw-bit signed.
  function automatic longint model_err(input scan_t s, input int errw);
    longint acc, hi, lo;
    acc = (longint'(s.l0) - longint'(s.r0))
        + (longint'(s.l1) - longint'(s.r1)) * 8
        + (longint'(s.l2) - longint'(s.r2)) * 64;
    hi = (longint'(1) << (errw - 1)) - 1;
    lo = -(longint'(1) << (errw - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  // A2D model for dut_a: fixed latency, results from a per-channel table.
  logic [11:0] tbl_a [6];
  int pend_a = 0, pch_a = 0, last_a = 0;
  initial begin
    cmplt_a = 1'b0;
    res_a   = '0;
    forever begin
      @(negedge clk);
      cmplt_a = 1'b0;
      if (pend_a > 0) begin
        pend_a--;
        if (pend_a == 0) begin
          cmplt_a = 1'b1;
          res_a   = tbl_a[pch_a];
          last_a  = cyc;
        end
      end
      if (strt_a) begin
        pend_a = 3;
        pch_a  = int'(ch_a);
      end
    end
  end

  // A2D model for dut_b: random latency, optional stray cnv_cmplt pulses
  // (including one in the same cycle as strt_cnv), optional mute.
  logic [11:0] tbl_b [6];
  int pend_b = 0, pch_b = 0, last_b = 0, lat_max_b = 1;
  bit spur_b = 1'b0, mute_b = 1'b0;
  initial begin
    cmplt_b = 1'b0;
    res_b   = '0;
    forever begin
      @(negedge clk);
      cmplt_b = 1'b0;
      if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) begin
          cmplt_b = 1'b1;
          res_b   = tbl_b[pch_b];
          last_b  = cyc;
        end
      end else if (spur_b && !strt_b && $urandom_range(0, 7) == 0) begin
        cmplt_b = 1'b1;
        res_b   = 12'($urandom);
      end
      if (strt_b && !mute_b) begin
        pend_b = int'($urandom_range(1, lat_max_b));
        pch_b  = int'(ch_b);
        if (spur_b && $urandom_range(0, 1) == 1) begin
          cmplt_b = 1'b1;
          res_b   = 12'($urandom);
        end
      end
    end
  end

  // Monitors: channel / emitter at each start pulse, err_vld pulses, one-hot emitters.
  int ch_q_a[$], ir_q_a[$], ch_q_b[$], ir_q_b[$];
  int vldcnt_a = 0, vldcnt_b = 0;
  bit multihot = 1'b0;
  initial forever begin
    @(negedge clk);
    if (strt_a) begin ch_q_a.push_back(int'(ch_a)); ir_q_a.push_back(int'(ir_a)); end
    if (strt_b) begin ch_q_b.push_back(int'(ch_b)); ir_q_b.push_back(int'(ir_b)); end
    if (vld_a) vldcnt_a++;
    if (vld_b) vldcnt_b++;
    if ($countones(ir_a) > 1 || $countones(ir_b) > 1) multihot = 1'b1;
  end

  function automatic longint pack_q(input int q[$]);
    longint v = 0;
    if (q.size() != 6) return -1;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic load_b(input scan_t s);
    tbl_b[0] = s.l0; tbl_b[1] = s.r0; tbl_b[2] = s.l1;
    tbl_b[3] = s.r1; tbl_b[4] = s.l2; tbl_b[5] = s.r2;
  endtask

  task automatic run_scan_b(input scan_t s, input longint exp, input string name);
    int t = 0;
    load_b(s);
    ch_q_b.delete();
    ir_q_b.delete();
    go_b = 1'b1;
    do begin tick(); t++; end while (!vld_b && t < 2000);
    check({name, "_vld_seen"}, vld_b, 1);
    if (vld_b) begin
      check({name, "_err"}, err_b, exp);
      check({name, "_latency"}, cyc - last_b, 2);
      check({name, "_chseq"}, pack_q(ch_q_b), 64'h012345);
      check({name, "_irseq"}, pack_q(ir_q_b), 64'h112244);
    end
    go_b = 1'b0;
    tick();
    check({name, "_pulse1"}, vld_b, 0);
    tick();
    check({name, "_idle"}, busy_b, 0);
  endtask

  vec_t vecs [8];

  initial begin
    int t, n, v0;
    longint e0;
    scan_t s;
    rst_n = 1'b0;
    go_a  = 1'b1;
    go_b  = 1'b0;
    tbl_a[0] = 12'h100; tbl_a[1] = 12'h080; tbl_a[2] = 12'h200;
    tbl_a[3] = 12'h200; tbl_a[4] = 12'h000; tbl_a[5] = 12'h010;

    vecs[0] = '{s: '{l0: 0, r0: 0, l1: 0, r1: 0, l2: 12'hFFF, r2: 0}, exp: 2047};
    vecs[1] = '{s: '{l0: 0, r0: 0, l1: 0, r1: 0, l2: 0, r2: 12'hFFF}, exp: -2048};
    vecs[2] = '{s: '{l0: 12'h100, r0: 12'h080, l1: 12'h200, r1: 12'h200, l2: 0, r2: 12'h010}, exp: -896};
    vecs[3] = '{s: '{l0: 12'h7FF, r0: 0, l1: 0, r1: 0, l2: 0, r2: 0}, exp: 2047};
    vecs[4] = '{s: '{l0: 0, r0: 12'hFFF, l1: 0, r1: 0, l2: 0, r2: 0}, exp: -2048};
    vecs[5] = '{s: '{l0: 0, r0: 0, l1: 12'h01F, r1: 0, l2: 0, r2: 0}, exp: 248};
    vecs[6] = '{s: '{l0: 12'h555, r0: 12'h555, l1: 12'h555, r1: 12'h555, l2: 12'h555, r2: 12'h555}, exp: 0};
    vecs[7] = '{s: '{l0: 5, r0: 3, l1: 1, r1: 2, l2: 2, r2: 1}, exp: 58};

    // Reset held with go high: everything quiet.
    repeat (4) tick();
    check("rst_strt", strt_a, 0);
    check("rst_ir_en", ir_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_vld", vld_a, 0);
    check("rst_chnnl", ch_a, 0);
    check("rst_a2d_err", a2e_a, 0);

    // Release: emitter 0 on for exactly SETTLE_CYC cycles, then chnnl 0 start.
    rst_n = 1'b1;
    t = 0;
    n = 0;
    do begin
      tick();
      t++;
      if (strt_a) break;
      if (ir_a == 3'b001 && busy_a) n++;
    end while (t < 5000);
    check("settle_len", n, 4096);
    check("first_strt", strt_a, 1);
    check("first_chnnl", ch_a, 0);
    check("first_ir_en", ir_a, 1);

    // Default scan: err=-896; go held so next scan restarts right away.
    t = 0;
    do begin tick(); t++; end while (!vld_a && t < 20000);
    check("a_vld_seen", vld_a, 1);
    check("a_err", err_a, -896);
    check("a_latency", cyc - last_a, 2);
    check("a_chseq", pack_q(ch_q_a), 64'h012345);
    check("a_irseq", pack_q(ir_q_a), 64'h112244);
    check("a_restart_ir", ir_a, 1);
    check("a_restart_busy", busy_a, 1);
    tbl_a[0] = 12'h010; tbl_a[1] = 0; tbl_a[2] = 0;
    tbl_a[3] = 0; tbl_a[4] = 0; tbl_a[5] = 0;
    tick();
    check("a_pulse1", vld_a, 0);
    t = 0;
    do begin tick(); t++; end while (!vld_a && t < 20000);
    check("a2_err", err_a, 16);
    check("a2_vld_count", vldcnt_a, 2);
    go_a = 1'b0;
    tick();
    tick();
    check("a_idle_busy", busy_a, 0);
    check("a_idle_ir", ir_a, 0);

    // Table-driven scans on the ERR_W=12 instance.
    lat_max_b = 4;
    spur_b = 1'b1;
    foreach (vecs[i]) run_scan_b(vecs[i].s, longint'(vecs[i].exp), $sformatf("vec%0d", i));

    // Randomized scans against the reference model.
    lat_max_b = 5;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        s = '{l0: 12'($urandom), r0: 12'($urandom), l1: 12'($urandom),
              r1: 12'($urandom), l2: 12'($urandom), r2: 12'($urandom)};
      end else begin
        s = '{l0: 12'($urandom_range(0, 63)), r0: 12'($urandom_range(0, 63)),
              l1: 12'($urandom_range(0, 63)), r1: 12'($urandom_range(0, 63)),
              l2: 12'($urandom_range(0, 31)), r2: 12'($urandom_range(0, 31))};
      end
      run_scan_b(s, model_err(s, 12), $sformatf("rnd%0d", i));
    end

    // go dropped in WAIT_L of pair 1: finish that conversion, then idle quietly.
    load_b(vecs[7].s);
    lat_max_b = 4;
    ch_q_b.delete();
    ir_q_b.delete();
    e0 = longint'(err_b);
    v0 = vldcnt_b;
    go_b = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!(strt_b && ch_b == 3'd2) && t < 500);
    check("drop_strt2_seen", strt_b, 1);
    tick();
    go_b = 1'b0;
    t = 0;
    while (!(pend_b == 0 && cmplt_b) && t < 20) begin tick(); t++; end
    check("drop_cmplt_seen", cmplt_b, 1);
    tick();
    check("drop_busy", busy_b, 0);
    check("drop_ir_en", ir_b, 0);
    repeat (30) tick();
    check("drop_no_more_strt", ch_q_b.size(), 3);
    check("drop_no_vld", vldcnt_b - v0, 0);
    check("drop_err_held", err_b, e0);

`ifdef IR_SEQ_TIMEOUT_EN
    // Silent A2D: watchdog trips after 16 WAIT cycles and the flag sticks.
    spur_b = 1'b0;
    mute_b = 1'b1;
    go_b = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!strt_b && t < 500);
    n = 0;
    do begin tick(); n++; end while (!a2e_b && n < 100);
    check("to_cycles", n, 17);
    check("to_ir_en", ir_b, 0);
    check("to_busy", busy_b, 0);
    go_b = 1'b0;
    repeat (3) tick();
    go_b = 1'b1;
    repeat (5) tick();
    go_b = 1'b0;
    check("to_sticky", a2e_b, 1);
    rst_n = 1'b0;
    tick();
    check("to_cleared", a2e_b, 0);
    rst_n = 1'b1;
    mute_b = 1'b0;
`else
    check("a2d_err_tied", a2e_b, 0);
`endif

    check("onehot_ir_en", multihot, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
